// File: rtl/mult_div_unit_if.sv
// EX-stage handshake and HI/LO result bus of the multiply/divide unit.
// The EX stage drives through master; the unit itself connects as slave.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             start;
   logic             mthi;
   logic             mtlo;
   logic             cancel;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output a, b, op, start, mthi, mtlo, cancel,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  a, b, op, start, mthi, mtlo, cancel,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply/accumulate and a
// one-bit-per-cycle restoring divider, with cancel and divide-by-zero reporting.
module mult_div_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;
   localparam int CNT_MAX = (MULT_LAT > WIDTH) ? MULT_LAT : WIDTH;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         kind_q, kind_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic [2*WIDTH-1:0] ext_a, ext_b, acc, mul_res;
   logic [WIDTH:0]     shift, diff;
   logic               sa, sb;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      prod_d  = prod_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      zero_d  = zero_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;

      ext_a = bus.op[0] ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
      ext_b = bus.op[0] ? {{WIDTH{1'b0}}, bus.b} : {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
      sa    = !bus.op[0] && bus.a[WIDTH-1];
      sb    = !bus.op[0] && bus.b[WIDTH-1];
      acc   = {hi_q, lo_q};
      // kind_q holds op[2:1]: 0x plain product, 10 accumulate, 11 subtract
      if (!kind_q[1])      mul_res = prod_q;
      else if (!kind_q[0]) mul_res = acc + prod_q;
      else                 mul_res = acc - prod_q;
      // Restoring step: the borrow out of diff means the divisor did not fit
      shift = {rem_q, quo_q[WIDTH-1]};
      diff  = shift - {1'b0, dvs_q};

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.cancel) begin
               kind_d = bus.op[2:1];
               if (!bus.op[1] || bus.op[2]) begin
                  prod_d  = ext_a * ext_b;
                  cnt_d   = CW'(MULT_LAT);
                  state_d = S_MUL;
               end else begin
                  rem_d   = '0;
                  quo_d   = sa ? -bus.a : bus.a;
                  dvs_d   = sb ? -bus.b : bus.b;
                  negq_d  = sa ^ sb;
                  negr_d  = sa;
                  zero_d  = (bus.b == '0);
                  cnt_d   = CW'(WIDTH);
                  state_d = (bus.b == '0) ? S_FIX : S_DIV;
               end
            end else if (!bus.cancel) begin
               if (bus.mthi) hi_d = bus.a;
               if (bus.mtlo) lo_d = bus.a;
            end
         end
         S_MUL: begin
            if (bus.cancel) begin
               state_d = S_IDLE;
            end else if (cnt_q == CW'(1)) begin
               {hi_d, lo_d} = mul_res;
               done_d       = 1'b1;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            if (bus.cancel) begin
               state_d = S_IDLE;
            end else begin
               rem_d = diff[WIDTH] ? shift[WIDTH-1:0] : diff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], !diff[WIDTH]};
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = S_FIX;
            end
         end
         default: begin
            if (!bus.cancel) begin
               done_d = 1'b1;
               dz_d   = zero_q;
               if (!zero_q) begin
                  lo_d = negq_q ? -quo_q : quo_q;
                  hi_d = negr_q ? -rem_q : rem_q;
               end
            end
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         kind_q  <= '0;
         prod_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         zero_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
         prod_q  <= prod_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         zero_q  <= zero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised HI/LO multiply/divide unit for the pipelined MIPS core, driven from the EX stage.
- Executes mult/multu/div/divu and the accumulate ops madd/maddu/msub/msubu.
- Division is a real iterative restoring divider, one quotient bit per cycle, not a delayed one-shot result.
- Adds width/latency parameters, divide-by-zero reporting, a done pulse and a cancel input for exception flush.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MULT_LAT, 5, cycles busy is high for any multiply-class op (must be >= 1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A (rs); also the mthi/mtlo data.
- b  input  WIDTH  operand B (rt).
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
- start  input  1  request an op; sampled only when idle.
- mthi  input  1  write a to HI.
- mtlo  input  1  write a to LO.
- cancel  input  1  abort the in-flight op or suppress a start.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO are updated (or on divide-by-zero completion).
- div_zero  output  1  one-cycle pulse, coincident with done, for div/divu with b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset==0, immediate, regardless of clk): hi=0, lo=0, busy=0, done=0, div_zero=0, FSM=IDLE, counters cleared. Reset mid-operation discards the op.
- FSM states:
  - IDLE: accepts start, mthi, mtlo.
  - MUL: latency count.
  - DIV: WIDTH iterations.
  - FIX: sign correction and writeback.
- Transitions:
  - IDLE, start && !cancel, op[1]==0 or op[2]==1: go to MUL.
  - IDLE, start && !cancel, op in {010, 011}, b!=0: go to DIV.
  - IDLE, start && !cancel, op in {010, 011}, b==0: go to FIX with a zero flag set.
- Start edge E0: the unit registers the operands and sets busy=1. Ops are issued only while busy==0; start while busy is ignored and does not queue.
- Multiply:
  - Signed ops (op[0]==0) form the 2*WIDTH signed product; unsigned ops form the unsigned product. The product is registered at E0.
  - The counter loads MULT_LAT and decrements each edge.
  - At edge E0+MULT_LAT:
    - mult/multu: {hi,lo} <= product.
    - madd/maddu: {hi,lo} <= {hi,lo} + product.
    - msub/msubu: {hi,lo} <= {hi,lo} - product.
    - Arithmetic wraps modulo 2^(2*WIDTH). The same edge sets busy=0 and done=1 for one cycle.
  - busy is high for exactly MULT_LAT cycles.
- Divide:
  - At E0 the unit captures the magnitudes (div: absolute value, divu: raw) and the signs of a and b.
  - DIV runs WIDTH shift/subtract iterations, one per edge.
  - FIX (one edge) writes the results:
    - lo = quotient, negated if the signs differ (div only).
    - hi = remainder, taking the sign of the dividend.
    - busy=0, done=1.
  - busy is high for WIDTH+1 cycles.
  - Overflow case div 0x80000000 / -1: lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero: busy is high for 1 cycle (FIX only). hi and lo are unchanged; done=1 and div_zero=1 together.
- mthi/mtlo:
  - Honoured only in IDLE; take effect at the edge they are sampled.
  - Ignored while busy.
  - If start is accepted in the same cycle, start wins and mthi/mtlo are dropped.
  - mthi and mtlo together write both registers.
- cancel:
  - While busy: at the next edge the FSM returns to IDLE, busy=0, no done, hi/lo unchanged. This includes the final (writeback) edge, where cancel beats the writeback.
  - While idle: suppresses start and mthi/mtlo in that cycle.
- done and div_zero are 0 in every cycle other than the completion cycle.

Test Plan:
- WIDTH=32, MULT_LAT=5. mult a=0xFFFFFFFE, b=3 -> busy high for 5 cycles; at completion hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse of 1 cycle. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- divu a=100, b=7 -> busy for 33 cycles, lo=14, hi=2. div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x1234, then mtlo 0x5678, then div a=5, b=0 -> busy 1 cycle; done and div_zero pulse together; hi=0x1234, lo=0x5678 unchanged.
- mtlo 0xFFFFFFFF with hi=0, then madd 1*1 -> hi=1, lo=0. Then msub 1*1 -> hi=0, lo=0xFFFFFFFF.
- Abort and priority cases:
  - mult, then assert cancel in the 3rd busy cycle -> busy=0 on the next edge, no done, hi/lo unchanged.
  - start while busy -> ignored.
  - start together with mthi in IDLE -> hi not written by mthi.
- Assert reset low asynchronously mid-divu (between clock edges) -> busy, hi, lo, done all 0 immediately. After reset is released, a new divu 9/3 completes with lo=3, hi=0.
